// File: rtl/timer_seq_ctrl_if.sv
// Bundle of the sequencer's configuration, control and timer-side signals.
interface timer_seq_ctrl_if #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PW    = 32,
  parameter int unsigned OW    = 12
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [PW-1:0] cfg_period;
  logic [OW-1:0] cfg_pattern;
  logic          cfg_last;
  logic          start;
  logic          stop;
  logic          loop;
  logic          tmr_load;
  logic [PW-1:0] tmr_period;
  logic          tmr_en;
  logic          tmr_expire;
  logic [OW-1:0] pat_out;
  logic [AW-1:0] step_idx;
  logic          busy;
  logic          done;
  logic          err;

  // Sequencer side.
  modport slave (
    input  cfg_we, cfg_addr, cfg_period, cfg_pattern, cfg_last,
    input  start, stop, loop, tmr_expire,
    output tmr_load, tmr_period, tmr_en, pat_out, step_idx, busy, done, err
  );

  // Firmware/timer side.
  modport master (
    output cfg_we, cfg_addr, cfg_period, cfg_pattern, cfg_last,
    output start, stop, loop, tmr_expire,
    input  tmr_load, tmr_period, tmr_en, pat_out, step_idx, busy, done, err
  );
endinterface

// File: rtl/timer_seq_ctrl.sv
// Steps the user timer through a table of (period, pattern) entries and drives the IO pattern.
module timer_seq_ctrl #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PW    = 32,
  parameter int unsigned OW    = 12
) (
  input logic             wb_clk_i,
  input logic             wb_rst_n_i,
  timer_seq_ctrl_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  state_e        state_q;
  logic [AW-1:0] idx_q;
  logic          loop_q;
  logic          tmr_load_q;
  logic [PW-1:0] tmr_period_q;
  logic          tmr_en_q;
  logic [OW-1:0] pat_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;

  logic [PW-1:0]    period_q  [DEPTH];
  logic [OW-1:0]    pattern_q [DEPTH];
  logic [DEPTH-1:0] last_q;

  logic [AW-1:0] idx_inc;
  logic          wrap;
  logic [PW-1:0] start_period;

  // Next-entry decode and same-edge write bypass for entry 0 at start.
  always_comb begin
    idx_inc      = idx_q + AW'(1);
    wrap         = last_q[idx_q] || (idx_q == LastIdx);
    start_period = (bus.cfg_we && (bus.cfg_addr == '0)) ? bus.cfg_period : period_q[0];
  end

  // Table storage; writes only land while idle.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        period_q[i]  <= '0;
        pattern_q[i] <= '0;
      end
      last_q <= '0;
    end else if (bus.cfg_we && (state_q == StIdle)) begin
      period_q[bus.cfg_addr]  <= bus.cfg_period;
      pattern_q[bus.cfg_addr] <= bus.cfg_pattern;
      last_q[bus.cfg_addr]    <= bus.cfg_last;
    end
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      loop_q       <= 1'b0;
      tmr_load_q   <= 1'b0;
      tmr_period_q <= '0;
      tmr_en_q     <= 1'b0;
      pat_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      tmr_load_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      if (bus.stop) begin
        // Abort wins over everything else, silently.
        state_q  <= StIdle;
        idx_q    <= '0;
        tmr_en_q <= 1'b0;
        pat_q    <= '0;
        busy_q   <= 1'b0;
      end else begin
        if (bus.cfg_we && (state_q != StIdle)) begin
          err_q <= 1'b1;
        end
        unique case (state_q)
          StIdle: begin
            if (bus.start) begin
              state_q      <= StLoad;
              idx_q        <= '0;
              loop_q       <= bus.loop;
              tmr_load_q   <= 1'b1;
              tmr_period_q <= start_period;
              pat_q        <= '0;
              busy_q       <= 1'b1;
            end
          end
          StLoad: begin
            if (tmr_period_q == '0) begin
              // A zero period would never expire: abandon the sequence.
              state_q <= StIdle;
              err_q   <= 1'b1;
              pat_q   <= '0;
              busy_q  <= 1'b0;
            end else begin
              state_q  <= StRun;
              tmr_en_q <= 1'b1;
              pat_q    <= pattern_q[idx_q];
            end
          end
          StRun: begin
            if (bus.tmr_expire) begin
              tmr_en_q <= 1'b0;
              if (!wrap) begin
                state_q      <= StLoad;
                idx_q        <= idx_inc;
                tmr_load_q   <= 1'b1;
                tmr_period_q <= period_q[idx_inc];
              end else if (loop_q) begin
                state_q      <= StLoad;
                idx_q        <= '0;
                tmr_load_q   <= 1'b1;
                tmr_period_q <= period_q[0];
              end else begin
                state_q <= StDone;
                done_q  <= 1'b1;
              end
            end
          end
          StDone: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.tmr_load   = tmr_load_q;
  assign bus.tmr_period = tmr_period_q;
  assign bus.tmr_en     = tmr_en_q;
  assign bus.pat_out    = pat_q;
  assign bus.step_idx   = idx_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_timer_seq_ctrl.sv
// Directed bench for timer_seq_ctrl; the bench plays both firmware and timer.
module tb_timer_seq_ctrl;
  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  timer_seq_ctrl_if #(.DEPTH(8), .PW(32), .OW(12)) bus ();

  timer_seq_ctrl #(.DEPTH(8), .PW(32), .OW(12)) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int addr, input int per, input int pat, input logic last);
    bus.cfg_we      = 1'b1;
    bus.cfg_addr    = 3'(addr);
    bus.cfg_period  = 32'(per);
    bus.cfg_pattern = 12'(pat);
    bus.cfg_last    = last;
    tick();
    bus.cfg_we = 1'b0;
  endtask

  task automatic do_start(input logic lp);
    bus.start = 1'b1;
    bus.loop  = lp;
    tick();
    bus.start = 1'b0;
    bus.loop  = 1'b0;
  endtask

  task automatic do_stop();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
  endtask

  // Entered in the LOAD cycle of an entry; leaves in the cycle after its expiry.
  task automatic run_entry(input int idx, input int per, input int pat);
    chk("load", 32'(bus.tmr_load), 1);
    chk("period", bus.tmr_period, 32'(per));
    chk("step_idx", 32'(bus.step_idx), 32'(idx));
    chk("en_in_load", 32'(bus.tmr_en), 0);
    tick();
    chk("en_run", 32'(bus.tmr_en), 1);
    chk("pat", 32'(bus.pat_out), 32'(pat));
    repeat (per - 1) tick();
    bus.tmr_expire = 1'b1;
    tick();
    bus.tmr_expire = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_load"}, 32'(bus.tmr_load), 0);
    chk({tag, "_period"}, bus.tmr_period, 0);
    chk({tag, "_en"}, 32'(bus.tmr_en), 0);
    chk({tag, "_pat"}, 32'(bus.pat_out), 0);
    chk({tag, "_idx"}, 32'(bus.step_idx), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_err"}, 32'(bus.err), 0);
  endtask

  initial begin
    vectors         = 0;
    miscompares     = 0;
    rst_n           = 1'b1;
    bus.cfg_we      = 1'b0;
    bus.cfg_addr    = '0;
    bus.cfg_period  = '0;
    bus.cfg_pattern = '0;
    bus.cfg_last    = 1'b0;
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    bus.loop        = 1'b0;
    bus.tmr_expire  = 1'b0;

    #1 rst_n = 1'b0;
    #2;
    chk_all_zero("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // One-shot three-entry sequence.
    wr(0, 5, 12'h001, 1'b0);
    wr(1, 3, 12'h0F0, 1'b0);
    wr(2, 4, 12'hA5A, 1'b1);
    do_start(1'b0);
    chk("busy_start", 32'(bus.busy), 1);
    run_entry(0, 5, 12'h001);
    run_entry(1, 3, 12'h0F0);
    run_entry(2, 4, 12'hA5A);
    chk("done_pulse", 32'(bus.done), 1);
    chk("done_en", 32'(bus.tmr_en), 0);
    chk("done_busy", 32'(bus.busy), 1);
    tick();
    chk("done_gone", 32'(bus.done), 0);
    chk("busy_fall", 32'(bus.busy), 0);
    chk("pat_hold", 32'(bus.pat_out), 12'hA5A);
    tick();
    chk("pat_hold2", 32'(bus.pat_out), 12'hA5A);

    // Looping sequence, two passes then stop.
    do_start(1'b1);
    for (int p = 0; p < 2; p++) begin
      run_entry(0, 5, 12'h001);
      run_entry(1, 3, 12'h0F0);
      run_entry(2, 4, 12'hA5A);
    end
    chk("loop_reload", 32'(bus.tmr_load), 1);
    chk("loop_idx0", 32'(bus.step_idx), 0);
    tick();
    do_stop();
    chk("stop_en", 32'(bus.tmr_en), 0);
    chk("stop_pat", 32'(bus.pat_out), 0);
    chk("stop_idx", 32'(bus.step_idx), 0);
    chk("stop_busy", 32'(bus.busy), 0);
    chk("stop_done", 32'(bus.done), 0);
    chk("stop_err", 32'(bus.err), 0);

    // No last flags: index runs to DEPTH-1 then finishes.
    for (int i = 0; i < 8; i++) wr(i, 2, i + 1, 1'b0);
    do_start(1'b0);
    for (int i = 0; i < 8; i++) run_entry(i, 2, i + 1);
    chk("wrap_done", 32'(bus.done), 1);
    tick();

    // Zero period on entry 1 aborts with err.
    wr(1, 0, 12'h0F0, 1'b0);
    do_start(1'b0);
    run_entry(0, 2, 1);
    chk("zp_load", 32'(bus.tmr_load), 1);
    chk("zp_period", bus.tmr_period, 0);
    chk("zp_idx", 32'(bus.step_idx), 1);
    tick();
    chk("zp_err", 32'(bus.err), 1);
    chk("zp_busy", 32'(bus.busy), 0);
    chk("zp_en", 32'(bus.tmr_en), 0);
    chk("zp_pat", 32'(bus.pat_out), 0);
    tick();
    chk("zp_err_gone", 32'(bus.err), 0);
    chk("zp_en_low", 32'(bus.tmr_en), 0);
    chk("zp_done", 32'(bus.done), 0);

    // Write and start while busy are rejected.
    wr(1, 2, 12'h002, 1'b0);
    do_start(1'b0);
    tick();
    wr(0, 9, 12'hFFF, 1'b1);
    chk("busy_we_err", 32'(bus.err), 1);
    do_start(1'b0);
    chk("busy_start_idx", 32'(bus.step_idx), 0);
    chk("busy_start_noload", 32'(bus.tmr_load), 0);
    chk("busy_start_en", 32'(bus.tmr_en), 1);
    do_stop();
    do_start(1'b0);
    chk("kept_period", bus.tmr_period, 2);
    tick();
    chk("kept_pat", 32'(bus.pat_out), 12'h001);

    // stop, start and expire together in RUN.
    bus.stop       = 1'b1;
    bus.start      = 1'b1;
    bus.tmr_expire = 1'b1;
    tick();
    bus.stop       = 1'b0;
    bus.start      = 1'b0;
    bus.tmr_expire = 1'b0;
    chk("sse_load", 32'(bus.tmr_load), 0);
    chk("sse_busy", 32'(bus.busy), 0);
    chk("sse_en", 32'(bus.tmr_en), 0);
    chk("sse_pat", 32'(bus.pat_out), 0);
    tick();
    chk("sse_load2", 32'(bus.tmr_load), 0);

    // Asynchronous reset mid-RUN.
    do_start(1'b0);
    tick();
    chk("pre_rst_en", 32'(bus.tmr_en), 1);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    #1 rst_n = 1'b1;
    tick();

    // Table lost: entry 0 is zero-period again.
    do_start(1'b0);
    chk("lost_period", bus.tmr_period, 0);
    tick();
    chk("lost_err", 32'(bus.err), 1);

    // Start with a same-edge write to entry 0 uses the new entry.
    bus.cfg_we      = 1'b1;
    bus.cfg_addr    = 3'd0;
    bus.cfg_period  = 32'd7;
    bus.cfg_pattern = 12'h3C3;
    bus.cfg_last    = 1'b1;
    do_start(1'b0);
    bus.cfg_we = 1'b0;
    chk("bypass_period", bus.tmr_period, 7);
    tick();
    chk("bypass_pat", 32'(bus.pat_out), 12'h3C3);
    do_stop();
    chk("final_pat", 32'(bus.pat_out), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
